// File: rtl/binary_add_arbiter_pkg.sv
// Shared types and helpers for the shared-adder arbiter slice.
package binary_add_pkg;

  localparam int ADD_WIDTH = 13;
  localparam int MAX_NREQ  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Round-robin pick: first set valid bit scanning upward from ptr, wrapping
  // at nreq. Returns a one-hot vector (all zero when nothing is valid).
  function automatic logic [MAX_NREQ-1:0] rr_pick(input logic [MAX_NREQ-1:0] valid,
                                                  input logic [2:0]          ptr,
                                                  input int                  nreq);
    logic [MAX_NREQ-1:0] pick;
    logic                found;
    int                  idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= nreq) idx = idx - nreq;
      if (!found && (k < nreq) && valid[idx[2:0]]) begin
        pick[idx[2:0]] = 1'b1;
        found          = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/binary_add_arbiter_if.sv
// Requester and response handshake bundle for the shared-adder arbiter.
interface binary_add_arbiter_if
  import binary_add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;

  // Client side: issues operands and consumes results.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

  // Arbiter side: grants requesters and produces results.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

endinterface

// File: rtl/binary_add_arbiter_add_rca.sv
// WIDTH-bit ripple-carry adder built as a chain of full-adder cells.
module add_rca
  import binary_add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  // One full-adder cell per bit; carry ripples from LSB to MSB.
  for (genvar g = 0; g < WIDTH; g++) begin : g_fa
    assign sum[g]     = a[g] ^ b[g] ^ carry[g];
    assign carry[g+1] = (a[g] & b[g]) | (carry[g] & (a[g] ^ b[g]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/binary_add_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder among NREQ requesters.
// Each operation runs IDLE (grant) -> CALC (add) -> RESP (hold until taken).
module binary_add_arbiter
  import binary_add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int CNTW  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  binary_add_arbiter_if.slave  bus,
  output logic                 busy,
  output logic [CNTW-1:0]      ops_done
);

  state_t              state, next_state;
  logic [IDW-1:0]      rr_ptr, gnt_id, next_ptr, op_id, rsp_id_q;
  logic [NREQ-1:0]     grant;
  logic [MAX_NREQ-1:0] valid_ext, pick_full;
  logic                unused_pick;
  logic [WIDTH-1:0]    sel_a, sel_b, op_a, op_b, add_sum, rsp_sum_q;
  logic                add_cout, rsp_carry_q;

  // Grant selection: only in IDLE with en high and reset released, so
  // req_ready stays low during reset and whenever an op is in flight.
  always_comb begin
    valid_ext             = '0;
    pick_full             = '0;
    grant                 = '0;
    gnt_id                = '0;
    sel_a                 = '0;
    sel_b                 = '0;
    valid_ext[NREQ-1:0]   = bus.req_valid;
    if (rst_n && (state == IDLE) && en)
      pick_full = rr_pick(valid_ext, 3'(rr_ptr), NREQ);
    for (int i = 0; i < NREQ; i++) begin
      if (pick_full[i]) begin
        grant[i] = 1'b1;
        gnt_id   = IDW'(i);
        sel_a    = bus.req_a[i*WIDTH +: WIDTH];
        sel_b    = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign unused_pick = ^pick_full;
  assign next_ptr    = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

  // Next-state logic for the three-phase operation sequence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|grant) next_state = CALC;
      CALC:    next_state = RESP;
      RESP:    if (bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Capture the winner's operands and advance the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_id  <= '0;
    end else if (|grant) begin
      rr_ptr <= next_ptr;
      op_a   <= sel_a;
      op_b   <= sel_b;
      op_id  <= gnt_id;
    end
  end

  add_rca #(.WIDTH(WIDTH)) u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Register the adder result during CALC; it is held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_id_q    <= '0;
    end else if (state == CALC) begin
      rsp_sum_q   <= add_sum;
      rsp_carry_q <= add_cout;
      rsp_id_q    <= op_id;
    end
  end

  // Count accepted responses; the counter wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              ops_done <= '0;
    else if ((state == RESP) && bus.rsp_ready) ops_done <= ops_done + CNTW'(1);
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_binary_add_arbiter.sv
// Self-checking bench for binary_add_arbiter: directed scenarios plus
// randomized traffic against a round-robin / arithmetic reference model.
// The counter is instantiated narrow so its wrap is reachable quickly.
module tb_binary_add_arbiter;
  import binary_add_pkg::*;

  localparam int WIDTH = 13;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int CNTW  = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             busy;
  logic [CNTW-1:0]  ops_done;

  binary_add_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  binary_add_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .bus      (bus),
    .busy     (busy),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int fails     = 0;
  int model_ptr = 0;
  int model_ops = 0;

  logic [WIDTH-1:0] a_in [NREQ];
  logic [WIDTH-1:0] b_in [NREQ];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_operands();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*WIDTH +: WIDTH] = a_in[i];
      bus.req_b[i*WIDTH +: WIDTH] = b_in[i];
    end
  endtask

  task automatic random_operands();
    for (int i = 0; i < NREQ; i++) begin
      a_in[i] = WIDTH'($urandom);
      b_in[i] = WIDTH'($urandom);
    end
    load_operands();
  endtask

  // Reference arbiter: first valid requester at or after the pointer, modulo NREQ.
  task automatic model_grant(input logic [NREQ-1:0] vmask, output int g);
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (g < 0 && vmask[(model_ptr + k) % NREQ]) g = (model_ptr + k) % NREQ;
    end
    if (g >= 0) model_ptr = (g + 1) % NREQ;
  endtask

  function automatic logic [WIDTH:0] model_add(input int g);
    int s;
    s = int'(a_in[g]) + int'(b_in[g]);
    return (WIDTH+1)'(s);
  endfunction

  // Drives one full operation and reports what the DUT showed.
  task automatic transact(input logic [NREQ-1:0] vmask, input int stall, input bit drop_en,
                          output logic [NREQ-1:0] rdy, output int lat,
                          output logic [IDW-1:0] id, output logic [WIDTH-1:0] sum,
                          output logic carry);
    bus.rsp_ready = (stall == 0);
    bus.req_valid = vmask;
    #1;
    rdy = bus.req_ready;
    tick();
    if (drop_en) en = 1'b0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    id    = bus.rsp_id;
    sum   = bus.rsp_sum;
    carry = bus.rsp_carry;
    for (int s = 0; s < stall; s++) tick();
    bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = '0;
    en            = 1'b1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    en            = 1'b1;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    random_operands();
    #3;
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, busy, ops_done, bus.req_ready} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_values: got valid=%b id=%0d sum=%0d carry=%b busy=%b ops=%0d ready=%b, want all 0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, busy, ops_done, bus.req_ready);
    end
    #10 rst_n = 1'b1;
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    logic [NREQ-1:0] rdy; int lat; logic [IDW-1:0] id; logic [WIDTH-1:0] sum; logic carry; int g;
    a_in[0] = 13'd100;
    b_in[0] = 13'd23;
    load_operands();
    model_grant(4'b0001, g);
    transact(4'b0001, 0, 1'b0, rdy, lat, id, sum, carry);
    model_ops = (model_ops + 1) % (1 << CNTW);
    checks++; if (rdy !== 4'b0001) begin fails++; $display("[TB] FAIL single_ready: got %b want 0001", rdy); end
    checks++; if (lat !== 2) begin fails++; $display("[TB] FAIL single_latency: got %0d want 2", lat); end
    checks++; if (sum !== 13'd123) begin fails++; $display("[TB] FAIL single_sum: got %0d want 123", sum); end
    checks++; if (carry !== 1'b0) begin fails++; $display("[TB] FAIL single_carry: got %b want 0", carry); end
    checks++; if (id !== 2'd0) begin fails++; $display("[TB] FAIL single_id: got %0d want 0", id); end
    checks++; if (ops_done !== CNTW'(1)) begin fails++; $display("[TB] FAIL single_ops: got %0d want 1", ops_done); end
  endtask

  task automatic test_overflow();
    logic [NREQ-1:0] rdy; int lat; logic [IDW-1:0] id; logic [WIDTH-1:0] sum; logic carry; int g;
    a_in[0] = 13'd8191; b_in[0] = 13'd1;
    a_in[3] = 13'd8191; b_in[3] = 13'd8191;
    load_operands();
    model_grant(4'b0001, g);
    transact(4'b0001, 0, 1'b0, rdy, lat, id, sum, carry);
    model_ops = (model_ops + 1) % (1 << CNTW);
    checks++; if ({carry, sum} !== {1'b1, 13'd0}) begin fails++; $display("[TB] FAIL ovf_8191_1: got carry=%b sum=%0d want carry=1 sum=0", carry, sum); end
    model_grant(4'b1000, g);
    transact(4'b1000, 0, 1'b0, rdy, lat, id, sum, carry);
    model_ops = (model_ops + 1) % (1 << CNTW);
    checks++; if ({carry, sum} !== {1'b1, 13'd8190}) begin fails++; $display("[TB] FAIL ovf_8191_8191: got carry=%b sum=%0d want carry=1 sum=8190", carry, sum); end
    checks++; if (id !== 2'd3) begin fails++; $display("[TB] FAIL ovf_id: got %0d want 3", id); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] rdy; int lat; logic [IDW-1:0] id; logic [WIDTH-1:0] sum; logic carry; int g;
    logic [NREQ-1:0] masks [7] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1001, 4'b1001, 4'b1001};
    int              want  [7] = '{0, 1, 2, 3, 0, 3, 0};
    random_operands();
    for (int n = 0; n < 7; n++) begin
      model_grant(masks[n], g);
      transact(masks[n], 0, 1'b0, rdy, lat, id, sum, carry);
      model_ops = (model_ops + 1) % (1 << CNTW);
      checks++;
      if (id !== IDW'(want[n]) || rdy !== NREQ'(1 << g)) begin
        fails++;
        $display("[TB] FAIL rr_seq[%0d]: got id=%0d ready=%b want id=%0d ready=%b", n, id, rdy, want[n], NREQ'(1 << g));
      end
      checks++;
      if ({carry, sum} !== model_add(g)) begin
        fails++;
        $display("[TB] FAIL rr_sum[%0d]: got %0d want %0d", n, {carry, sum}, model_add(g));
      end
    end
  endtask

  task automatic test_back_pressure();
    int g;
    logic [WIDTH:0] exp;
    random_operands();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    model_grant(4'b1111, g);
    exp = model_add(g);
    #1;
    checks++; if (bus.req_ready !== NREQ'(1 << g)) begin fails++; $display("[TB] FAIL bp_grant: got %b want %b", bus.req_ready, NREQ'(1 << g)); end
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.rsp_valid, busy, bus.req_ready, bus.rsp_id, bus.rsp_carry, bus.rsp_sum} !==
          {1'b1, 1'b1, 4'b0000, IDW'(g), exp}) begin
        fails++;
        $display("[TB] FAIL bp_hold[%0d]: got valid=%b busy=%b ready=%b id=%0d sum=%0d want 1 1 0000 %0d %0d",
                 i, bus.rsp_valid, busy, bus.req_ready, bus.rsp_id, {bus.rsp_carry, bus.rsp_sum}, g, exp);
      end
      if (i < 4) tick();
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    tick();
    model_ops = (model_ops + 1) % (1 << CNTW);
    checks++;
    if ({busy, bus.rsp_valid, ops_done} !== {1'b0, 1'b0, CNTW'(model_ops)}) begin
      fails++;
      $display("[TB] FAIL bp_release: got busy=%b valid=%b ops=%0d want 0 0 %0d", busy, bus.rsp_valid, ops_done, model_ops);
    end
  endtask

  task automatic test_enable();
    logic [NREQ-1:0] rdy; int lat; logic [IDW-1:0] id; logic [WIDTH-1:0] sum; logic carry; int g;
    random_operands();
    en            = 1'b0;
    bus.req_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus.req_ready, busy} !== 5'b0) begin
        fails++;
        $display("[TB] FAIL en_gate[%0d]: got ready=%b busy=%b want 0000 0", i, bus.req_ready, busy);
      end
      tick();
    end
    en = 1'b1;
    model_grant(4'b0010, g);
    transact(4'b0010, 0, 1'b0, rdy, lat, id, sum, carry);
    model_ops = (model_ops + 1) % (1 << CNTW);
    checks++; if (rdy !== 4'b0010 || id !== 2'd1) begin fails++; $display("[TB] FAIL en_grant: got ready=%b id=%0d want 0010 1", rdy, id); end
    model_grant(4'b1000, g);
    transact(4'b1000, 0, 1'b1, rdy, lat, id, sum, carry);
    model_ops = (model_ops + 1) % (1 << CNTW);
    checks++;
    if (lat !== 2 || id !== IDW'(g) || {carry, sum} !== model_add(g)) begin
      fails++;
      $display("[TB] FAIL en_drop_midop: got lat=%0d id=%0d sum=%0d want 2 %0d %0d", lat, id, {carry, sum}, g, model_add(g));
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] rdy; int lat; logic [IDW-1:0] id; logic [WIDTH-1:0] sum; logic carry; int g;
    logic [NREQ-1:0] vmask;
    for (int n = 0; n < 40; n++) begin
      random_operands();
      vmask = NREQ'($urandom_range(1, 15));
      model_grant(vmask, g);
      transact(vmask, int'($urandom_range(0, 3)), 1'b0, rdy, lat, id, sum, carry);
      model_ops = (model_ops + 1) % (1 << CNTW);
      checks++;
      if (rdy !== NREQ'(1 << g) || lat !== 2 || id !== IDW'(g) || {carry, sum} !== model_add(g) ||
          ops_done !== CNTW'(model_ops)) begin
        fails++;
        $display("[TB] FAIL rand[%0d] mask=%b: got ready=%b lat=%0d id=%0d sum=%0d ops=%0d want %b 2 %0d %0d %0d",
                 n, vmask, rdy, lat, id, {carry, sum}, ops_done, NREQ'(1 << g), g, model_add(g), model_ops);
      end
    end
  endtask

  task automatic test_counter_wrap();
    logic [NREQ-1:0] rdy; int lat; logic [IDW-1:0] id; logic [WIDTH-1:0] sum; logic carry; int g;
    int guard = 0;
    while (model_ops != (1 << CNTW) - 1 && guard < 1000) begin
      random_operands();
      model_grant(4'b1111, g);
      transact(4'b1111, 0, 1'b0, rdy, lat, id, sum, carry);
      model_ops = (model_ops + 1) % (1 << CNTW);
      guard++;
    end
    checks++; if (ops_done !== {CNTW{1'b1}}) begin fails++; $display("[TB] FAIL wrap_max: got %0d want %0d", ops_done, (1 << CNTW) - 1); end
    model_grant(4'b0100, g);
    transact(4'b0100, 0, 1'b0, rdy, lat, id, sum, carry);
    model_ops = (model_ops + 1) % (1 << CNTW);
    checks++; if (ops_done !== '0) begin fails++; $display("[TB] FAIL wrap_zero: got %0d want 0", ops_done); end
  endtask

  task automatic test_reset_mid_calc();
    logic [NREQ-1:0] rdy; int lat; logic [IDW-1:0] id; logic [WIDTH-1:0] sum; logic carry; int g;
    a_in[0] = 13'd1;
    b_in[0] = 13'd2;
    load_operands();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0001;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin fails++; $display("[TB] FAIL rst_accept: got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, busy, ops_done, bus.req_ready} !== '0) begin
      fails++;
      $display("[TB] FAIL rst_midcalc: got valid=%b id=%0d sum=%0d carry=%b busy=%b ops=%0d ready=%b want all 0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, busy, ops_done, bus.req_ready);
    end
    tick();
    #3 rst_n = 1'b1;
    tick();
    model_ptr = 0;
    model_ops = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.rsp_valid, busy} !== 2'b00) begin
        fails++;
        $display("[TB] FAIL rst_no_resp[%0d]: got valid=%b busy=%b want 0 0", i, bus.rsp_valid, busy);
      end
      tick();
    end
    random_operands();
    model_grant(4'b0011, g);
    transact(4'b0011, 0, 1'b0, rdy, lat, id, sum, carry);
    model_ops = (model_ops + 1) % (1 << CNTW);
    checks++;
    if (id !== 2'd0 || {carry, sum} !== model_add(g) || ops_done !== CNTW'(1)) begin
      fails++;
      $display("[TB] FAIL rst_ptr_cleared: got id=%0d sum=%0d ops=%0d want 0 %0d 1", id, {carry, sum}, ops_done, model_add(g));
    end
  endtask

  // Sequence of scenarios followed by the single summary line.
  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_back_pressure();
    test_enable();
    test_random();
    test_counter_wrap();
    test_reset_mid_calc();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Guard against a hung handshake.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
